// File: rtl/seqcheck_param.sv
// Parametrised serial sequence detector: N-bit shift register compared against a
// runtime-loadable pattern with a per-bit don't-care mask, plus a saturating match counter.
module seqcheck_param #(
    parameter int             N       = 6,
    parameter logic [N-1:0]   PAT_RST = N'(6'b101011),
    parameter logic [N-1:0]   MSK_RST = {N{1'b1}},
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic [N-1:0]     msk_in,
    input  logic             cnt_clr,
    output logic             out,
    output logic [N-1:0]     state,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = $clog2(N + 1);

    logic [N-1:0]  pat;
    logic [N-1:0]  msk;
    logic [FW-1:0] fill;
    logic [N-1:0]  next_window;
    logic          hit;

    // Stream handshake: in is consumed on every rising edge where in_valid is 1; there
    // is no back-pressure. fill counts valid bits since reset/flush so stale bits can
    // never complete a window.
    always_comb begin
        next_window = {state[N-2:0], in};
        hit = in_valid && (fill >= FW'(N - 1)) && (((next_window ^ pat) & msk) == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= '0;
            fill      <= '0;
            out       <= 1'b0;
            match_cnt <= '0;
            pat       <= PAT_RST;
            msk       <= MSK_RST;
        end else begin
            // The counter is independent of pat_load, but a load edge ignores the stream.
            if (cnt_clr)
                match_cnt <= '0;
            else if (hit && !pat_load && match_cnt != '1)
                match_cnt <= match_cnt + 1'b1;

            if (pat_load) begin
                pat   <= pat_in;
                msk   <= msk_in;
                state <= '0;
                fill  <= '0;
                out   <= 1'b0;
            end else begin
                out <= hit;
                if (in_valid) begin
                    state <= next_window;
                    // Non-overlapping mode restarts the window count after a match.
                    if (hit && !overlap)
                        fill <= '0;
                    else if (fill != FW'(N))
                        fill <= fill + 1'b1;
                end
            end
        end
    end

endmodule
